// File: rtl/zsdram_port_arbiter.sv
// Two-port round-robin arbiter in front of the ZSDRAM base controller (iCall/oDone, one word per grant).
// Optional watchdog: define ZSDRAM_ARB_WDOG_EN to abort a WAIT that lasts TMO_CYC cycles and set sticky err.
module zsdram_port_arbiter #(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 16,
    parameter int TMO_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [1:0]        oCall,
    output logic [ADDR_W-1:0] oAddr,
    output logic [DATA_W-1:0] oData,
    input  logic [1:0]        iDone,
    input  logic [DATA_W-1:0] iData,
    output logic              err
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_GAP = 2'd2} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_last, r_gnt, r_op;
    logic [1:0]        r_call;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_ack0, r_ack1, r_err;
    logic [DATA_W-1:0] r_rdata0, r_rdata1;

    logic              w_any, w_sel, w_sel_we, w_done, w_tmo;
    logic              w_last_nxt, w_gnt_nxt, w_op_nxt;
    logic [1:0]        w_call_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] w_data_nxt;
    logic              w_ack0_nxt, w_ack1_nxt, w_err_nxt;
    logic [DATA_W-1:0] w_rdata0_nxt, w_rdata1_nxt;

    assign w_any    = req0 | req1;
    // On a tie the port that did not win last time is served.
    assign w_sel    = (req0 & req1) ? ~r_last : req1;
    assign w_sel_we = w_sel ? we1 : we0;
    assign w_done   = iDone[r_op];

`ifdef ZSDRAM_ARB_WDOG_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    logic [TMO_W-1:0] r_tmo_cnt;

    // Watchdog counter: counts WAIT cycles, cleared in every other state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= {TMO_W{1'b0}};
        end else if (r_state == ST_WAIT) begin
            r_tmo_cnt <= r_tmo_cnt + {{(TMO_W-1){1'b0}}, 1'b1};
        end else begin
            r_tmo_cnt <= {TMO_W{1'b0}};
        end
    end

    assign w_tmo = (r_state == ST_WAIT) && (r_tmo_cnt == TMO_W'(TMO_CYC - 1));
`else
    assign w_tmo = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; completion takes priority over a same-cycle timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = w_any ? ST_WAIT : ST_IDLE;
            ST_WAIT: w_state_nxt = (w_done || w_tmo) ? ST_GAP : ST_WAIT;
            ST_GAP:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and grant bookkeeping.
    always_comb begin
        w_last_nxt   = r_last;
        w_gnt_nxt    = r_gnt;
        w_op_nxt     = r_op;
        w_call_nxt   = r_call;
        w_addr_nxt   = r_addr;
        w_data_nxt   = r_data;
        w_ack0_nxt   = 1'b0;
        w_ack1_nxt   = 1'b0;
        w_rdata0_nxt = r_rdata0;
        w_rdata1_nxt = r_rdata1;
        w_err_nxt    = r_err;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_gnt_nxt  = w_sel;
                    w_op_nxt   = w_sel_we;
                    w_call_nxt = w_sel_we ? 2'b10 : 2'b01;
                    w_addr_nxt = w_sel ? addr1 : addr0;
                    w_data_nxt = w_sel ? wdata1 : wdata0;
                end else begin
                    w_call_nxt = 2'b00;
                end
            end
            ST_WAIT: begin
                if (w_done) begin
                    w_call_nxt = 2'b00;
                    w_last_nxt = r_gnt;
                    w_ack0_nxt = ~r_gnt;
                    w_ack1_nxt = r_gnt;
                    if (!r_op && !r_gnt) begin
                        w_rdata0_nxt = iData;
                    end else if (!r_op && r_gnt) begin
                        w_rdata1_nxt = iData;
                    end else begin
                        w_rdata0_nxt = r_rdata0;
                    end
                end else if (w_tmo) begin
                    w_call_nxt = 2'b00;
                    w_last_nxt = r_gnt;
                    w_err_nxt  = 1'b1;
                end else begin
                    w_call_nxt = r_call;
                end
            end
            ST_GAP:  w_call_nxt = 2'b00;
            default: w_call_nxt = 2'b00;
        endcase
    end

    // Output and grant registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last   <= 1'b1;
            r_gnt    <= 1'b0;
            r_op     <= 1'b0;
            r_call   <= 2'b00;
            r_addr   <= {ADDR_W{1'b0}};
            r_data   <= {DATA_W{1'b0}};
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_rdata0 <= {DATA_W{1'b0}};
            r_rdata1 <= {DATA_W{1'b0}};
            r_err    <= 1'b0;
        end else begin
            r_last   <= w_last_nxt;
            r_gnt    <= w_gnt_nxt;
            r_op     <= w_op_nxt;
            r_call   <= w_call_nxt;
            r_addr   <= w_addr_nxt;
            r_data   <= w_data_nxt;
            r_ack0   <= w_ack0_nxt;
            r_ack1   <= w_ack1_nxt;
            r_rdata0 <= w_rdata0_nxt;
            r_rdata1 <= w_rdata1_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign oCall  = r_call;
    assign oAddr  = r_addr;
    assign oData  = r_data;
    assign ack0   = r_ack0;
    assign ack1   = r_ack1;
    assign rdata0 = r_rdata0;
    assign rdata1 = r_rdata1;
    assign err    = r_err;

endmodule

// File: tb/tb_zsdram_port_arbiter.sv
// Directed bench for zsdram_port_arbiter; the bench itself plays the base controller.
// The watchdog scenario is built only when ZSDRAM_ARB_WDOG_EN is defined.
module tb_zsdram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [23:0] addr0 = 24'h0, addr1 = 24'h0;
    logic [15:0] wdata0 = 16'h0, wdata1 = 16'h0;
    logic        ack0, ack1, err;
    logic [15:0] rdata0, rdata1;
    logic [1:0]  oCall;
    logic [23:0] oAddr;
    logic [15:0] oData;
    logic [1:0]  iDone = 2'b00;
    logic [15:0] iData = 16'h0;

    int n_checks = 0;
    int n_err    = 0;

    zsdram_port_arbiter #(.ADDR_W(24), .DATA_W(16), .TMO_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .oCall(oCall), .oAddr(oAddr), .oData(oData),
        .iDone(iDone), .iData(iData), .err(err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_call(input string tag);
        int n = 0;
        while (oCall == 2'b00 && n < 8) begin
            cyc();
            n++;
        end
        chk({tag, "_granted"}, 32'(oCall != 2'b00), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

    initial begin
        logic exp_port;
        int   high_cnt;

        // Reset state
        cyc(); cyc();
        chk("rst_call", 32'(oCall), 32'd0);
        chk("rst_addr", 32'(oAddr), 32'd0);
        chk("rst_ack",  32'({ack0, ack1}), 32'd0);
        chk("rst_rdata", {rdata0, rdata1}, 32'd0);
        chk("rst_err",  32'(err), 32'd0);
        rst = 1'b0;

        // T1: port 0 write, done 5 cycles after the call
        req0 = 1'b1; we0 = 1'b1; addr0 = 24'h000010; wdata0 = 16'hABCD;
        cyc();
        chk("t1_call", 32'(oCall), 32'h2);
        chk("t1_addr", 32'(oAddr), 32'h000010);
        chk("t1_data", 32'(oData), 32'hABCD);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t1_hold_call", 32'(oCall), 32'h2);
            chk("t1_no_ack", 32'(ack0), 32'd0);
        end
        iDone = 2'b10;
        cyc();
        chk("t1_ack0", 32'({ack0, ack1}), 32'h2);
        chk("t1_gap_call", 32'(oCall), 32'd0);
        iDone = 2'b00; req0 = 1'b0;
        cyc();
        chk("t1_ack_pulse", 32'(ack0), 32'd0);
        chk("t1_no_regrant", 32'(oCall), 32'd0);
        cyc();
        chk("t1_idle", 32'(oCall), 32'd0);

        // T2: port 1 read returns 0xABCD
        req1 = 1'b1; we1 = 1'b0; addr1 = 24'h000010;
        cyc();
        chk("t2_call", 32'(oCall), 32'h1);
        chk("t2_addr", 32'(oAddr), 32'h000010);
        iData = 16'hABCD; iDone = 2'b01;
        cyc();
        chk("t2_ack1", 32'({ack0, ack1}), 32'h1);
        chk("t2_rdata1", 32'(rdata1), 32'hABCD);
        chk("t2_rdata0", 32'(rdata0), 32'h0);
        iDone = 2'b00; iData = 16'h0; req1 = 1'b0;
        cyc(); cyc();

        // T3: both requesting, six operations alternate starting at port 0
        req0 = 1'b1; we0 = 1'b1; addr0 = 24'h000100; wdata0 = 16'h1111;
        req1 = 1'b1; we1 = 1'b0; addr1 = 24'h000200;
        for (int k = 0; k < 6; k++) begin
            exp_port = k[0];
            wait_call("t3");
            chk("t3_no_both", 32'(oCall == 2'b11), 32'd0);
            chk("t3_call", 32'(oCall), exp_port ? 32'h1 : 32'h2);
            chk("t3_addr", 32'(oAddr), exp_port ? 32'h200 : 32'h100);
            iDone = exp_port ? 2'b01 : 2'b10;
            iData = 16'h5000 + 16'(k);
            cyc();
            chk("t3_ack", 32'({ack0, ack1}), exp_port ? 32'h1 : 32'h2);
            if (exp_port) chk("t3_rdata1", 32'(rdata1), 32'h5000 + 32'(k));
            iDone = 2'b00;
            cyc();
            chk("t3_gap_call", 32'(oCall), 32'd0);
        end
        req0 = 1'b0; req1 = 1'b0;
        cyc(); cyc();

        // T6: read-done strobe during a write is ignored
        req0 = 1'b1; we0 = 1'b1; addr0 = 24'h000400; wdata0 = 16'h3333;
        cyc();
        chk("t6_call", 32'(oCall), 32'h2);
        iDone = 2'b01; iData = 16'hDEAD;
        cyc();
        chk("t6_ignore_ack", 32'(ack0), 32'd0);
        chk("t6_ignore_call", 32'(oCall), 32'h2);
        cyc();
        chk("t6_ignore_ack2", 32'(ack0), 32'd0);
        iDone = 2'b10;
        cyc();
        chk("t6_ack0", 32'(ack0), 32'd1);
        chk("t6_rdata0_kept", 32'(rdata0), 32'h0);
        iDone = 2'b00; iData = 16'h0; req0 = 1'b0;
        cyc(); cyc();

        // T4: reset during a write WAIT; port 0 then wins the tie
        req1 = 1'b1; we1 = 1'b1; addr1 = 24'h000500; wdata1 = 16'h4444;
        cyc();
        chk("t4_call1", 32'(oAddr), 32'h500);
        req0 = 1'b1; we0 = 1'b1; addr0 = 24'h000600; wdata0 = 16'h5555;
        cyc();
        chk("t4_wait_call", 32'(oCall), 32'h2);
        rst = 1'b1;
        #1;
        chk("t4_rst_call", 32'(oCall), 32'd0);
        chk("t4_rst_ack", 32'({ack0, ack1}), 32'd0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("t4_regrant_call", 32'(oCall), 32'h2);
        chk("t4_regrant_port0", 32'(oAddr), 32'h600);
        chk("t4_no_ack1", 32'(ack1), 32'd0);
        iDone = 2'b10;
        cyc();
        chk("t4_ack0", 32'({ack0, ack1}), 32'h2);
        iDone = 2'b00; req0 = 1'b0; req1 = 1'b0;
        cyc(); cyc();

`ifdef ZSDRAM_ARB_WDOG_EN
        // T5: base never answers; watchdog aborts after 16 WAIT cycles
        req0 = 1'b1; we0 = 1'b1; addr0 = 24'h000700; wdata0 = 16'h7777;
        cyc();
        high_cnt = 0;
        while (oCall != 2'b00 && high_cnt < 40) begin
            high_cnt++;
            chk("t5_ack0_quiet", 32'(ack0), 32'd0);
            cyc();
        end
        chk("t5_call_cycles", 32'(high_cnt), 32'd16);
        chk("t5_err", 32'(err), 32'd1);
        wait_call("t5_retry");
        chk("t5_retry_addr", 32'(oAddr), 32'h700);
        chk("t5_err_sticky", 32'(err), 32'd1);
        req0 = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t5_err_clear", 32'(err), 32'd0);
`else
        high_cnt = 0;
        chk("err_const", 32'(err), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
